// File: rtl/cntrl_pkg.sv
// Shared types for the bus-computer controller/sequencer: opcodes, one-hot
// T-state ring encoding and the 12-bit control word.
package cntrl_pkg;

  localparam int unsigned OPCODE_W = 4;
  localparam int unsigned TSTATE_W = 6;

  typedef enum logic [OPCODE_W-1:0] {
    OP_LDA = 4'b0000,
    OP_ADD = 4'b0001,
    OP_SUB = 4'b0010,
    OP_OUT = 4'b1110,
    OP_HLT = 4'b1111
  } opcode_e;

  typedef enum logic [TSTATE_W-1:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } tstate_e;

  typedef struct packed {
    logic en_pc;
    logic oe_pc;
    logic load_mar;
    logic oe_ram;
    logic we_ir;
    logic oe_ir;
    logic we_acc;
    logic oe_acc;
    logic sub;
    logic oe_alu;
    logic we_breg;
    logic load_or;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_NOP = '0;

  // Ring successor; any corrupted encoding falls back to T1.
  function automatic tstate_e next_tstate(input tstate_e t);
    case (t)
      T1:      return T2;
      T2:      return T3;
      T3:      return T4;
      T4:      return T5;
      T5:      return T6;
      default: return T1;
    endcase
  endfunction

endpackage

// File: rtl/cntrl_decode.sv
// Combinational control-word decode from the current T-state and IR opcode.
module cntrl_decode
  import cntrl_pkg::*;
(
  input  tstate_e              tstate,
  input  logic [OPCODE_W-1:0]  opcode,
  output ctrl_word_t           ctrl_c
);

  opcode_e op_c;
  assign op_c = opcode_e'(opcode);

  always_comb begin
    ctrl_c = CTRL_NOP;
    case (tstate)
      T1: begin
        ctrl_c.oe_pc    = 1'b1;
        ctrl_c.load_mar = 1'b1;
      end
      T2: ctrl_c.en_pc = 1'b1;
      T3: begin
        ctrl_c.oe_ram = 1'b1;
        ctrl_c.we_ir  = 1'b1;
      end
      T4: begin
        case (op_c)
          OP_LDA, OP_ADD, OP_SUB: begin
            ctrl_c.oe_ir    = 1'b1;
            ctrl_c.load_mar = 1'b1;
          end
          OP_OUT: begin
            ctrl_c.oe_acc  = 1'b1;
            ctrl_c.load_or = 1'b1;
          end
          default: ctrl_c = CTRL_NOP;
        endcase
      end
      T5: begin
        case (op_c)
          OP_LDA: begin
            ctrl_c.oe_ram = 1'b1;
            ctrl_c.we_acc = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ctrl_c.oe_ram  = 1'b1;
            ctrl_c.we_breg = 1'b1;
            ctrl_c.sub     = (op_c == OP_SUB);
          end
          default: ctrl_c = CTRL_NOP;
        endcase
      end
      T6: begin
        case (op_c)
          OP_ADD, OP_SUB: begin
            ctrl_c.oe_alu = 1'b1;
            ctrl_c.we_acc = 1'b1;
            ctrl_c.sub    = (op_c == OP_SUB);
          end
          default: ctrl_c = CTRL_NOP;
        endcase
      end
      default: ctrl_c = CTRL_NOP;
    endcase
  end

endmodule

// File: rtl/cntrl_sequencer.sv
// Six-state fetch/execute sequencer with sticky halt and run gating.
// Define CNTRL_SINGLE_STEP_EN to advance one T-state per synchronized step edge.
module cntrl_sequencer
  import cntrl_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 run,
  input  logic                 step,
  input  logic [OPCODE_W-1:0]  opcode,
  output logic                 en_PC,
  output logic                 OE_PC,
  output logic                 load_MAR,
  output logic                 OE_RAM,
  output logic                 WE_IR,
  output logic                 OE_IR,
  output logic                 WE_Acc,
  output logic                 OE_Acc,
  output logic                 SUB,
  output logic                 OE_ALU,
  output logic                 WE_Breg,
  output logic                 load_OR,
  output logic                 halted,
  output logic [TSTATE_W-1:0]  tstate
);

  tstate_e    tstate_q, tstate_d;
  logic       halted_q, halted_d;
  logic       advance_c;
  ctrl_word_t dec_c;
  ctrl_word_t ctrl_c;

`ifdef CNTRL_SINGLE_STEP_EN
  logic step_s1_q, step_s1_d;
  logic step_s2_q, step_s2_d;
  logic step_prev_q, step_prev_d;
  logic step_rise_c;

  always_comb begin
    step_s1_d   = step;
    step_s2_d   = step_s1_q;
    step_prev_d = step_s2_q;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      step_s1_q   <= 1'b0;
      step_s2_q   <= 1'b0;
      step_prev_q <= 1'b0;
    end else begin
      step_s1_q   <= step_s1_d;
      step_s2_q   <= step_s2_d;
      step_prev_q <= step_prev_d;
    end
  end

  // One-cycle pulse per synchronized rising edge, so a held step advances once.
  assign step_rise_c = step_s2_q & ~step_prev_q;
  assign advance_c   = run & ~halted_q & step_rise_c;
`else
  logic unused_step;
  assign unused_step = step;
  assign advance_c   = run & ~halted_q;
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      tstate_q <= T1;
      halted_q <= 1'b0;
    end else begin
      tstate_q <= tstate_d;
      halted_q <= halted_d;
    end
  end

  // HLT at T4 sets the flag instead of advancing, freezing the ring at T4.
  always_comb begin
    tstate_d = tstate_q;
    halted_d = halted_q;
    if (advance_c) begin
      if ((tstate_q == T4) && (opcode == OP_HLT)) begin
        halted_d = 1'b1;
      end else begin
        tstate_d = next_tstate(tstate_q);
      end
    end
  end

  cntrl_decode u_decode (
    .tstate (tstate_q),
    .opcode (opcode),
    .ctrl_c (dec_c)
  );

  assign ctrl_c = (RESET && run && !halted_q) ? dec_c : CTRL_NOP;

  assign en_PC    = ctrl_c.en_pc;
  assign OE_PC    = ctrl_c.oe_pc;
  assign load_MAR = ctrl_c.load_mar;
  assign OE_RAM   = ctrl_c.oe_ram;
  assign WE_IR    = ctrl_c.we_ir;
  assign OE_IR    = ctrl_c.oe_ir;
  assign WE_Acc   = ctrl_c.we_acc;
  assign OE_Acc   = ctrl_c.oe_acc;
  assign SUB      = ctrl_c.sub;
  assign OE_ALU   = ctrl_c.oe_alu;
  assign WE_Breg  = ctrl_c.we_breg;
  assign load_OR  = ctrl_c.load_or;
  assign halted   = halted_q;
  assign tstate   = tstate_q;

endmodule

// File: tb/tb_cntrl_sequencer.sv
// Self-checking bench for cntrl_sequencer: vector table plus hand-written
// reset/halt/step sequences, with a one-bus-driver monitor.
module tb_cntrl_sequencer;

  localparam logic [11:0] C_EN_PC   = 12'b1000_0000_0000;
  localparam logic [11:0] C_OE_PC   = 12'b0100_0000_0000;
  localparam logic [11:0] C_LD_MAR  = 12'b0010_0000_0000;
  localparam logic [11:0] C_OE_RAM  = 12'b0001_0000_0000;
  localparam logic [11:0] C_WE_IR   = 12'b0000_1000_0000;
  localparam logic [11:0] C_OE_IR   = 12'b0000_0100_0000;
  localparam logic [11:0] C_WE_ACC  = 12'b0000_0010_0000;
  localparam logic [11:0] C_OE_ACC  = 12'b0000_0001_0000;
  localparam logic [11:0] C_SUB     = 12'b0000_0000_1000;
  localparam logic [11:0] C_OE_ALU  = 12'b0000_0000_0100;
  localparam logic [11:0] C_WE_BREG = 12'b0000_0000_0010;
  localparam logic [11:0] C_LD_OR   = 12'b0000_0000_0001;
  localparam logic [11:0] C_NONE    = 12'b0;

  localparam logic [11:0] F1 = C_OE_PC | C_LD_MAR;
  localparam logic [11:0] F2 = C_EN_PC;
  localparam logic [11:0] F3 = C_OE_RAM | C_WE_IR;

  localparam logic [5:0] S1 = 6'b000001;
  localparam logic [5:0] S2 = 6'b000010;
  localparam logic [5:0] S3 = 6'b000100;
  localparam logic [5:0] S4 = 6'b001000;
  localparam logic [5:0] S5 = 6'b010000;
  localparam logic [5:0] S6 = 6'b100000;

  logic       CLK, RESET, run, step;
  logic [3:0] opcode;
  logic       en_PC, OE_PC, load_MAR, OE_RAM, WE_IR, OE_IR, WE_Acc, OE_Acc;
  logic       SUB, OE_ALU, WE_Breg, load_OR, halted;
  logic [5:0] tstate;

  typedef struct {
    logic       run;
    logic [3:0] op;
    logic [5:0] ts;
    logic [11:0] ctrl;
    logic       hlt;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  logic monitor_on = 1'b0;

  cntrl_sequencer dut (
    .CLK(CLK), .RESET(RESET), .run(run), .step(step), .opcode(opcode),
    .en_PC(en_PC), .OE_PC(OE_PC), .load_MAR(load_MAR), .OE_RAM(OE_RAM),
    .WE_IR(WE_IR), .OE_IR(OE_IR), .WE_Acc(WE_Acc), .OE_Acc(OE_Acc),
    .SUB(SUB), .OE_ALU(OE_ALU), .WE_Breg(WE_Breg), .load_OR(load_OR),
    .halted(halted), .tstate(tstate)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [11:0] ctrl_now();
    return {en_PC, OE_PC, load_MAR, OE_RAM, WE_IR, OE_IR,
            WE_Acc, OE_Acc, SUB, OE_ALU, WE_Breg, load_OR};
  endfunction

  // Compare current DUT outputs against one expected record.
  task automatic check_now(input string name, input vec_t e);
    logic [11:0] c;
    c = ctrl_now();
    n_cmp++;
    if (tstate !== e.ts || c !== e.ctrl || halted !== e.hlt) begin
      n_bad++;
      $display("FAIL %s: got tstate=%b ctrl=%b halted=%b, want tstate=%b ctrl=%b halted=%b",
               name, tstate, c, halted, e.ts, e.ctrl, e.hlt);
    end
  endtask

  // Drive inputs just after posedge, sample at negedge, return to posedge+1.
  task automatic apply(input string name, input vec_t v);
    vec_t e;
    run    = v.run;
    opcode = v.op;
    exp_q.push_back(v);
    @(negedge CLK);
    e = exp_q.pop_front();
    check_now(name, e);
    @(posedge CLK);
    #1;
  endtask

  function automatic vec_t mk(input logic r, input logic [3:0] op,
                              input logic [5:0] ts, input logic [11:0] c,
                              input logic h);
    vec_t v;
    v.run = r; v.op = op; v.ts = ts; v.ctrl = c; v.hlt = h;
    return v;
  endfunction

  task automatic add_instr(input logic [3:0] op, input logic [11:0] c4,
                           input logic [11:0] c5, input logic [11:0] c6);
    vecs.push_back(mk(1'b1, op, S1, F1, 1'b0));
    vecs.push_back(mk(1'b1, op, S2, F2, 1'b0));
    vecs.push_back(mk(1'b1, op, S3, F3, 1'b0));
    vecs.push_back(mk(1'b1, op, S4, c4, 1'b0));
    vecs.push_back(mk(1'b1, op, S5, c5, 1'b0));
    vecs.push_back(mk(1'b1, op, S6, c6, 1'b0));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
    end
    #1;
  endtask

  always @(negedge CLK) begin
    if (monitor_on) begin
      n_cmp++;
      if ($countones({OE_PC, OE_RAM, OE_IR, OE_Acc, OE_ALU}) > 1) begin
        n_bad++;
        $display("FAIL one_driver: OE_PC/RAM/IR/Acc/ALU=%b%b%b%b%b, want at most one high",
                 OE_PC, OE_RAM, OE_IR, OE_Acc, OE_ALU);
      end
    end
  end

  initial begin
    RESET = 1'b0; run = 1'b0; step = 1'b0; opcode = 4'b0000;
    @(posedge CLK);
    #1;
    monitor_on = 1'b1;

    apply("reset_run0", mk(1'b0, 4'h0, S1, C_NONE, 1'b0));
    apply("reset_run1", mk(1'b1, 4'h0, S1, C_NONE, 1'b0));
    RESET = 1'b1;

`ifndef CNTRL_SINGLE_STEP_EN
    add_instr(4'b0000, C_OE_IR | C_LD_MAR, C_OE_RAM | C_WE_ACC, C_NONE);
    add_instr(4'b0001, C_OE_IR | C_LD_MAR, C_OE_RAM | C_WE_BREG, C_OE_ALU | C_WE_ACC);
    add_instr(4'b0010, C_OE_IR | C_LD_MAR, C_OE_RAM | C_WE_BREG | C_SUB,
              C_SUB | C_OE_ALU | C_WE_ACC);
    add_instr(4'b1110, C_OE_ACC | C_LD_OR, C_NONE, C_NONE);
    add_instr(4'b0101, C_NONE, C_NONE, C_NONE);
    add_instr(4'b1011, C_NONE, C_NONE, C_NONE);
    // Run gating: drop run at T5 of an LDA, then resume at the same state.
    vecs.push_back(mk(1'b1, 4'b0000, S1, F1, 1'b0));
    vecs.push_back(mk(1'b1, 4'b0000, S2, F2, 1'b0));
    vecs.push_back(mk(1'b1, 4'b0000, S3, F3, 1'b0));
    vecs.push_back(mk(1'b1, 4'b0000, S4, C_OE_IR | C_LD_MAR, 1'b0));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(1'b0, 4'b0000, S5, C_NONE, 1'b0));
    vecs.push_back(mk(1'b1, 4'b0000, S5, C_OE_RAM | C_WE_ACC, 1'b0));
    vecs.push_back(mk(1'b1, 4'b0000, S6, C_NONE, 1'b0));
    // HLT: T4 is already silent, then the ring freezes at T4.
    vecs.push_back(mk(1'b1, 4'b1111, S1, F1, 1'b0));
    vecs.push_back(mk(1'b1, 4'b1111, S2, F2, 1'b0));
    vecs.push_back(mk(1'b1, 4'b1111, S3, F3, 1'b0));
    vecs.push_back(mk(1'b1, 4'b1111, S4, C_NONE, 1'b0));
    for (int i = 0; i < 20; i++) vecs.push_back(mk(1'b1, 4'b1111, S4, C_NONE, 1'b1));
    for (int i = 0; i < 2; i++) vecs.push_back(mk(1'b1, 4'b0001, S4, C_NONE, 1'b1));

    foreach (vecs[i]) begin
      apply($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset pulse clears halt asynchronously.
    RESET = 1'b0;
    #1;
    check_now("halt_reset_async", mk(1'b1, 4'b0001, S1, C_NONE, 1'b0));
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    apply("post_halt_t1", mk(1'b1, 4'b0001, S1, F1, 1'b0));
    apply("post_halt_t2", mk(1'b1, 4'b0001, S2, F2, 1'b0));
    apply("post_halt_t3", mk(1'b1, 4'b0001, S3, F3, 1'b0));

    // Reset mid-instruction at T4 abandons it and returns to T1.
    RESET = 1'b0;
    #1;
    check_now("mid_reset_async", mk(1'b1, 4'b0001, S1, C_NONE, 1'b0));
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    apply("mid_reset_t1", mk(1'b1, 4'b0001, S1, F1, 1'b0));
    apply("mid_reset_t2", mk(1'b1, 4'b0001, S2, F2, 1'b0));
`else
    // Without step edges the ring never leaves T1.
    for (int i = 0; i < 3; i++) apply("step_idle", mk(1'b1, 4'b0000, S1, F1, 1'b0));
    step = 1'b1;
    ticks(10);
    apply("step_held", mk(1'b1, 4'b0000, S2, F2, 1'b0));
    apply("step_held2", mk(1'b1, 4'b0000, S2, F2, 1'b0));
    step = 1'b0;
    ticks(4);
    for (int p = 0; p < 3; p++) begin
      step = 1'b1;
      ticks(2);
      step = 1'b0;
      ticks(4);
    end
    apply("step_pulses", mk(1'b1, 4'b0000, S5, C_OE_RAM | C_WE_ACC, 1'b0));
    apply("step_hold_t5", mk(1'b1, 4'b0000, S5, C_OE_RAM | C_WE_ACC, 1'b0));
    // Pulse while run is low is ignored.
    run = 1'b0;
    step = 1'b1;
    ticks(2);
    step = 1'b0;
    ticks(4);
    apply("step_run0", mk(1'b0, 4'b0000, S5, C_NONE, 1'b0));
    RESET = 1'b0;
    #1;
    check_now("step_reset", mk(1'b0, 4'b0000, S1, C_NONE, 1'b0));
    @(posedge CLK);
    #1;
    RESET = 1'b1;
`endif

    monitor_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cntrl_sequencer.md
# cntrl_sequencer

Controller/sequencer for the 8-bit bus computer (module slot `CNTRL`, select 4'b0111). It is the automatic counterpart of the manual `sel`/`OE`/`WE`/`load` front-end: rather than accepting a control word from switches, it decodes the opcode held in the instruction register and issues the per-module bus enables itself, one T-state per clock. A six-state ring (T1..T6) fetches each instruction and then executes it.

## Interface
- `OP_LDA`, 4'b0000: load Acc from RAM[operand].
- `OP_ADD`, 4'b0001: Acc = Acc + RAM[operand].
- `OP_SUB`, 4'b0010: Acc = Acc - RAM[operand].
- `OP_OUT`, 4'b1110: Acc is copied to the output register.
- `OP_HLT`, 4'b1111: stop the sequencer.
- `CLK`  in  1  single system clock; all state changes on the rising edge.
- `RESET`  in  1  asynchronous, active-low; clears all state.
- `run`  in  1  gate; while low the ring holds and every control output is 0.
- `step`  in  1  single-step request. Used only when `CNTRL_SINGLE_STEP_EN` is defined; otherwise ignored.
- `opcode`  in  4  upper nibble of IR contents.
- `en_PC`  out  1  PC increment enable.
- `OE_PC`  out  1  PC drives the bus.
- `load_MAR`  out  1  MAR latches from the bus.
- `OE_RAM`  out  1  RAM drives the bus.
- `WE_IR`  out  1  IR latches from the bus.
- `OE_IR`  out  1  IR operand nibble drives the bus.
- `WE_Acc`  out  1  Acc latches from the bus.
- `OE_Acc`  out  1  Acc drives the bus.
- `SUB`  out  1  ALU subtract select.
- `OE_ALU`  out  1  ALU drives the bus.
- `WE_Breg`  out  1  B register latches from the bus.
- `load_OR`  out  1  output register latches from the bus.
- `halted`  out  1  sticky halt flag.
- `tstate`  out  6  one-hot ring position; bit 0 = T1.

## Operation
- **Ring.** Order is T1→T2→T3→T4→T5→T6→T1. Every instruction takes 6 states; there is no early exit.
- **Fetch, same for all opcodes:**
  - T1: `OE_PC`, `load_MAR`.
  - T2: `en_PC`.
  - T3: `OE_RAM`, `WE_IR`.
- **Execute, decoded from `opcode`:**
  - T4: LDA/ADD/SUB drive `OE_IR`, `load_MAR`. OUT drives `OE_Acc`, `load_OR`. HLT sets `halted`.
  - T5: LDA drives `OE_RAM`, `WE_Acc`. ADD/SUB drive `OE_RAM`, `WE_Breg`. SUB also drives `SUB`.
  - T6: ADD drives `OE_ALU`, `WE_Acc`. SUB drives `SUB`, `OE_ALU`, `WE_Acc`.
- **Unlisted opcodes** execute as NOP: T4–T6 assert no control, and the ring still completes all 6 states.
- **Halt.** Once `halted` is set, the ring freezes at T4 and all control outputs are 0. Only `RESET` clears it.
- **At most one bus driver** (`OE_*`) is asserted in any state. This is a required invariant.
- **Output decode.** Control outputs are combinational from the registered `tstate`, `opcode`, `halted` and `run`. There is no path from `step` to the outputs.

## Timing
- **Reset values:** `tstate` = 6'b000001 (T1), `halted` = 0. All control outputs are 0 while `RESET` is low.
- **After release,** the first T1 control word is visible in the first cycle with `run` = 1.
- **One advance per qualifying clock edge.** An edge qualifies when `run` = 1, `halted` = 0, and (step mode only) a step pulse is present.
- **`opcode` must be stable from T4 to T6.** IR is written at the end of T3, so the new value is valid at T4.
- **`run` dropping mid-instruction:** the ring holds its position and resumes from the same T-state. There is no restart.
- **Reset asserted mid-instruction:** the ring returns to T1 immediately (asynchronously). The partially executed instruction is abandoned.
- **`halted` timing:** it is set on the clock edge that ends T4 with `opcode` = HLT. During T4 itself all outputs are already 0.

## Configuration
- **`CNTRL_SINGLE_STEP_EN` defined:**
  - `step` passes through a 2-flop synchronizer and a rising-edge detector.
  - The ring advances exactly one state per detected rising edge, provided `run` = 1.
  - `step` held high produces only one advance.
  - Synchronizer flops reset to 0.
- **`CNTRL_SINGLE_STEP_EN` not defined:**
  - `step` is unused.
  - The ring advances on every clock edge while `run` = 1.

## Structure
- **Package `cntrl_pkg`:**
  - opcode constants / `opcode_e` enum.
  - `tstate_e` with one-hot encoding.
  - `ctrl_word_t`, a packed struct holding the 12 control bits.
  - `CTRL_NOP` constant (all zeros).
- **Sub-module `cntrl_decode`:** purely combinational; maps `tstate` + `opcode` to `ctrl_word_t`.
- **Top level** owns the ring register, the halt flag, run/step gating and output masking.

## Test plan
- **Fetch after reset:** release `RESET`, `run` = 1, `opcode` = 4'b0000 → cycle 0 has `OE_PC` = `load_MAR` = 1; cycle 1 has `en_PC` = 1; cycle 2 has `OE_RAM` = `WE_IR` = 1; `tstate` = 6'b000100 in cycle 2.
- **SUB execute:** `opcode` = 4'b0010 → T5 has `OE_RAM`, `WE_Breg`, `SUB`; T6 has `SUB`, `OE_ALU`, `WE_Acc`; the next cycle is T1 with `SUB` = 0.
- **HLT:** `opcode` = 4'b1111 → `halted` = 1 after T4; then 20 further clocks → `tstate` stays 6'b001000 and all outputs are 0. Pulsing `RESET` low returns the ring to T1 with `halted` = 0.
- **Run gating:** drop `run` at T5 for 5 cycles → outputs are 0 and `tstate` holds at 6'b010000; raise `run` → the T5 control word reappears, then T6.
- **Illegal opcode:** `opcode` = 4'b0101 → T4–T6 have all outputs 0, and T1 follows after 6 states.
- **Single step (macro defined):** `step` held high for 10 clocks → exactly one advance, T1→T2; 3 separate pulses → `tstate` = 6'b010000 (T5). Across all scenarios, assert that at most one `OE_*` is high in any cycle.
